mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Sequential arbiter that shares one single-port, fixed-latency memory between the IF stage (instruction fetch) and the MEM stage (LD/ST from the decoded MEM_R_EN / MEM_W_EN).
- Sits between the pipeline and the memory model.
- Serializes accesses, counts out memory latency, returns read data with one-cycle ready pulses, and drives `freeze` to stall the pipeline while a data access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 4, memory cycles per access; legal range 1..15
- `MAX_DATA_BURST`, 4, consecutive data grants allowed before a waiting fetch is forced through (used only with `MEM_ARB_FAIRNESS_EN`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `if_req`  in  1  fetch request, level, held until `if_ready`
- `if_addr`  in  ADDR_W  fetch address
- `if_ready`  out  1  one-cycle pulse, `if_rdata` valid
- `if_rdata`  out  DATA_W  fetched word, registered, holds until next fetch completes
- `d_rd_en`  in  1  data read request, level
- `d_wr_en`  in  1  data write request, level
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_ready`  out  1  one-cycle pulse, data access complete
- `d_rdata`  out  DATA_W  load data, registered, holds until next data read completes
- `freeze`  out  1  pipeline stall
- `mem_cs`  out  1  memory select
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid in last BUSY cycle

## Operation
- States: IDLE, BUSY, DONE. Owner register: DATA or INST. Latency counter `cnt`.
- IDLE:
  - If `d_rd_en|d_wr_en`, grant DATA; else if `if_req`, grant INST.
  - On grant: latch address, wdata and write flag; owner <= grantee; `cnt` <= 0; go to BUSY.
  - No request: stay in IDLE.
- Both `d_rd_en` and `d_wr_en` high: treat as a write; `d_rdata` is not updated.
- BUSY:
  - `mem_cs`=1; `mem_addr`/`mem_wdata` come from the latches; `mem_we`=1 only for a data write.
  - `cnt` increments each cycle.
  - At `cnt==MEM_LAT-1`: if the access is a read, capture `mem_rdata` into the owner's rdata register; go to DONE.
- DONE:
  - Lasts exactly one cycle; owner's ready=1; no grant is made.
  - Then IDLE, so the requester can drop its request before re-arbitration.
- `mem_cs`, `mem_we`, `mem_addr`, `mem_wdata` are 0 in IDLE and DONE.
- `freeze` = (`d_rd_en|d_wr_en`) AND NOT (state==DONE AND owner==DATA). Combinational.
- Fetch stalls are signalled only through `if_ready`.
- Request dropped mid-access: the access still completes and ready still pulses.
- Address/data changes after grant are ignored.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, `cnt`=0, owner=DATA, all outputs 0 (including both rdata registers). Any in-flight access is aborted immediately with no ready pulse; `freeze` still follows its equation.
- Request seen in IDLE at cycle 0:
  - BUSY in cycles 1..MEM_LAT.
  - DONE (ready=1) in cycle MEM_LAT+1.
  - IDLE in cycle MEM_LAT+2.
- Back-to-back throughput: one access per MEM_LAT+2 cycles.
- MEM_LAT=1: one BUSY cycle; capture happens at `cnt`=0.
- Simultaneous DATA and INST requests in IDLE: DATA always wins (subject to Configuration). INST is granted at the next IDLE cycle.

## Configuration
- `MEM_ARB_FAIRNESS_EN` defined:
  - A saturating burst counter increments on each DATA grant made while `if_req`=1.
  - It clears on any INST grant, and in any IDLE cycle with `if_req`=0.
  - When it equals `MAX_DATA_BURST` in IDLE with `if_req`=1, INST is granted even if data is pending. `freeze` stays high throughout.
- `MEM_ARB_FAIRNESS_EN` undefined: strict data priority, no burst counter; fetch can starve indefinitely.

## Test plan
- Reset: assert `rst`=0 mid-BUSY (`mem_cs`=1) -> all outputs 0 in the same cycle. Release; first request is granted normally.
- Data read, MEM_LAT=4: `d_rd_en`=1, `d_addr`=0x40 at cycle 0, `mem_rdata`=0xDEADBEEF.
  - `mem_cs`=1, `mem_addr`=0x40 in cycles 1-4.
  - `d_ready`=1 and `d_rdata`=0xDEADBEEF in cycle 5.
  - `freeze` high in cycles 0-4, low in cycle 5.
- Data write: `d_wr_en`=1, `d_addr`=0x80, `d_wdata`=0x12345678 -> `mem_we`=1 with that address/data in cycles 1-4; `d_ready` in cycle 5; `d_rdata` unchanged.
- Contention: `if_req` (`if_addr`=0x8) and `d_rd_en` both at cycle 0; data drops at cycle 6.
  - `d_ready` at cycle 5.
  - INST granted at cycle 6, BUSY 7-10, `if_ready` at cycle 11 with captured data.
- MEM_LAT=1: single fetch -> `mem_cs` only in cycle 1, `if_ready` in cycle 2, next grant possible in cycle 3.
- Fairness, with `MEM_ARB_FAIRNESS_EN`, MAX_DATA_BURST=2: continuous data requests and `if_req`=1.
  - Grant order is DATA, DATA, INST, DATA.
  - With the macro undefined, the order is all DATA.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes IF-stage fetches and MEM-stage loads/stores onto one fixed-latency memory.
// Optional macro MEM_ARB_FAIRNESS_EN bounds consecutive data grants so a waiting fetch cannot starve.
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MEM_LAT        = 4,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_rd_en,
    input  logic              d_wr_en,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              freeze,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {OWN_INST, OWN_DATA} owner_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    if (MEM_LAT < 1 || MEM_LAT > 15 || MAX_DATA_BURST < 1) begin : g_bad_param
        $error("mem_arbiter: MEM_LAT must be 1..15 and MAX_DATA_BURST at least 1");
    end

    state_t              r_state;
    state_t              w_next;
    owner_t              r_owner;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                w_d_req;
    logic                w_force_inst;
    logic                w_grant_d;
    logic                w_grant_i;
    logic                w_last;

    assign w_d_req   = d_rd_en | d_wr_en;
    assign w_last    = r_cnt == LAST_CNT;
    assign w_grant_d = (r_state == IDLE) && w_d_req && !w_force_inst;
    assign w_grant_i = (r_state == IDLE) && if_req && (!w_d_req || w_force_inst);
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int BW = $clog2(MAX_DATA_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);

    logic [BW-1:0] r_burst;

    assign w_force_inst = if_req && (r_burst == BURST_MAX);

    // Counts data grants that overtook a waiting fetch; saturates at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_burst <= '0;
        end else if (r_state == IDLE) begin
            if (!if_req || w_grant_i)
                r_burst <= '0;
            else if (w_grant_d && r_burst != BURST_MAX)
                r_burst <= r_burst + 1'b1;
        end
    end
`else
    assign w_force_inst = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_owner    <= OWN_DATA;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_d || w_grant_i) begin
                r_owner <= w_grant_d ? OWN_DATA : OWN_INST;
                r_addr  <= w_grant_d ? d_addr : if_addr;
                r_wdata <= w_grant_d ? d_wdata : '0;
                r_we    <= w_grant_d & d_wr_en;
                r_cnt   <= '0;
            end else if (r_state == BUSY && !w_last) begin
                r_cnt <= r_cnt + 4'd1;
            end
            // A simultaneous read+write is a write, so loads capture only when r_we is clear.
            if (r_state == BUSY && w_last && !r_we) begin
                if (r_owner == OWN_DATA)
                    r_d_rdata <= mem_rdata;
                else
                    r_if_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_ready  = 1'b0;
        d_ready   = 1'b0;
        unique case (r_state)
            IDLE: w_next = (w_grant_d || w_grant_i) ? BUSY : IDLE;
            BUSY: begin
                w_next    = w_last ? DONE : BUSY;
                mem_cs    = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
            end
            default: begin
                w_next   = IDLE;
                if_ready = r_owner == OWN_INST;
                d_ready  = r_owner == OWN_DATA;
            end
        endcase
        freeze = w_d_req && !d_ready;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter at MEM_LAT=4 (u0) and MEM_LAT=1 (u1).
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 0, d_rd_en = 0, d_wr_en = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic        if_ready, d_ready, freeze, mem_cs, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_req1 = 0;
    logic [31:0] if_addr1 = 0, mem_rdata1 = 0;
    logic        if_ready1, d_ready1, freeze1, mem_cs1, mem_we1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4), .MAX_DATA_BURST(2)) u0 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rdata(if_rdata), .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata), .freeze(freeze),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_DATA_BURST(2)) u1 (
        .clk(clk), .rst(rst), .if_req(if_req1), .if_addr(if_addr1), .if_ready(if_ready1),
        .if_rdata(if_rdata1), .d_rd_en(1'b0), .d_wr_en(1'b0), .d_addr(32'h0),
        .d_wdata(32'h0), .d_ready(d_ready1), .d_rdata(d_rdata1), .freeze(freeze1),
        .mem_cs(mem_cs1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1)
    );

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic test_reset;
        tick;
        smp;
        n_cmp++;
        if ({mem_cs, mem_we, if_ready, d_ready, freeze, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: cs=%b we=%b ifr=%b dr=%b frz=%b addr=%h wd=%h ird=%h drd=%h, required all 0",
                     mem_cs, mem_we, if_ready, d_ready, freeze, mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        n_cmp++;
        if ({mem_cs1, if_ready1, if_rdata1} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs_lat1: cs=%b ifr=%b ird=%h, required all 0", mem_cs1, if_ready1, if_rdata1);
        end
        tick;
        rst = 1'b1;
        tick;
        d_rd_en = 1'b1;
        d_addr  = 32'h40;
        tick;
        tick;
        smp;
        n_cmp++;
        if (mem_cs !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pre_busy: mem_cs=%b required 1", mem_cs);
        end
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if ({mem_cs, mem_we, mem_addr, d_ready, if_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_abort: cs=%b we=%b addr=%h dr=%b ifr=%b, required all 0",
                     mem_cs, mem_we, mem_addr, d_ready, if_ready);
        end
        n_cmp++;
        if (freeze !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_freeze_eq: freeze=%b required 1", freeze);
        end
        d_rd_en = 1'b0;
        #1;
        n_cmp++;
        if (freeze !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_freeze_drop: freeze=%b required 0", freeze);
        end
        tick;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_read;
        tick;
        d_rd_en   = 1'b1;
        d_addr    = 32'h40;
        mem_rdata = 32'hDEADBEEF;
        smp;
        n_cmp++;
        if ({freeze, mem_cs} !== 2'b10) begin
            n_bad++;
            $display("FAIL read_c0: freeze=%b mem_cs=%b required 1 0", freeze, mem_cs);
        end
        for (int c = 1; c <= 4; c++) begin
            tick;
            smp;
            n_cmp++;
            if ({mem_cs, mem_we, freeze, d_ready, mem_addr} !== {4'b1010, 32'h40}) begin
                n_bad++;
                $display("FAIL read_busy c%0d: cs=%b we=%b frz=%b dr=%b addr=%h required 1 0 1 0 00000040",
                         c, mem_cs, mem_we, freeze, d_ready, mem_addr);
            end
        end
        tick;
        smp;
        n_cmp++;
        if ({d_ready, freeze, mem_cs, d_rdata} !== {3'b100, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL read_done: dr=%b frz=%b cs=%b rdata=%h required 1 0 0 deadbeef",
                     d_ready, freeze, mem_cs, d_rdata);
        end
        tick;
        d_rd_en = 1'b0;
        smp;
        n_cmp++;
        if ({d_ready, mem_cs, d_rdata} !== {2'b00, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL read_after: dr=%b cs=%b rdata=%h required 0 0 deadbeef", d_ready, mem_cs, d_rdata);
        end
    endtask

    task automatic test_write(input logic both);
        tick;
        d_wr_en   = 1'b1;
        d_rd_en   = both;
        d_addr    = 32'h80;
        d_wdata   = 32'h12345678;
        mem_rdata = 32'hCAFEF00D;
        for (int c = 1; c <= 4; c++) begin
            tick;
            smp;
            n_cmp++;
            if ({mem_cs, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h80, 32'h12345678}) begin
                n_bad++;
                $display("FAIL write_busy both=%b c%0d: cs=%b we=%b addr=%h wd=%h required 1 1 00000080 12345678",
                         both, c, mem_cs, mem_we, mem_addr, mem_wdata);
            end
        end
        tick;
        smp;
        n_cmp++;
        if ({d_ready, mem_we, d_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL write_done both=%b: dr=%b we=%b rdata=%h required 1 0 deadbeef",
                     both, d_ready, mem_we, d_rdata);
        end
        tick;
        d_wr_en = 1'b0;
        d_rd_en = 1'b0;
        tick;
    endtask

    task automatic test_contention;
        tick;
        if_req    = 1'b1;
        if_addr   = 32'h8;
        d_rd_en   = 1'b1;
        d_addr    = 32'h40;
        mem_rdata = 32'h11112222;
        for (int c = 1; c <= 4; c++) begin
            tick;
            smp;
            n_cmp++;
            if (mem_addr !== 32'h40) begin
                n_bad++;
                $display("FAIL cont_data_busy c%0d: addr=%h required 00000040", c, mem_addr);
            end
        end
        tick;
        smp;
        n_cmp++;
        if ({d_ready, if_ready, d_rdata} !== {2'b10, 32'h11112222}) begin
            n_bad++;
            $display("FAIL cont_d_done: dr=%b ifr=%b rdata=%h required 1 0 11112222", d_ready, if_ready, d_rdata);
        end
        tick;
        d_rd_en   = 1'b0;
        mem_rdata = 32'h33334444;
        smp;
        n_cmp++;
        if ({mem_cs, freeze} !== 2'b00) begin
            n_bad++;
            $display("FAIL cont_c6: cs=%b frz=%b required 0 0", mem_cs, freeze);
        end
        for (int c = 7; c <= 10; c++) begin
            tick;
            smp;
            n_cmp++;
            if ({mem_cs, mem_we, freeze, mem_addr} !== {3'b100, 32'h8}) begin
                n_bad++;
                $display("FAIL cont_inst_busy c%0d: cs=%b we=%b frz=%b addr=%h required 1 0 0 00000008",
                         c, mem_cs, mem_we, freeze, mem_addr);
            end
        end
        tick;
        smp;
        n_cmp++;
        if ({if_ready, d_ready, if_rdata, d_rdata} !== {2'b10, 32'h33334444, 32'h11112222}) begin
            n_bad++;
            $display("FAIL cont_i_done: ifr=%b dr=%b ird=%h drd=%h required 1 0 33334444 11112222",
                     if_ready, d_ready, if_rdata, d_rdata);
        end
        tick;
        if_req = 1'b0;
        tick;
    endtask

    task automatic test_lat1;
        tick;
        if_req1    = 1'b1;
        if_addr1   = 32'h10;
        mem_rdata1 = 32'hA5A5A5A5;
        tick;
        smp;
        n_cmp++;
        if ({mem_cs1, if_ready1, mem_addr1} !== {2'b10, 32'h10}) begin
            n_bad++;
            $display("FAIL lat1_c1: cs=%b ifr=%b addr=%h required 1 0 00000010", mem_cs1, if_ready1, mem_addr1);
        end
        tick;
        smp;
        n_cmp++;
        if ({mem_cs1, if_ready1, if_rdata1} !== {2'b01, 32'hA5A5A5A5}) begin
            n_bad++;
            $display("FAIL lat1_c2: cs=%b ifr=%b ird=%h required 0 1 a5a5a5a5", mem_cs1, if_ready1, if_rdata1);
        end
        tick;
        mem_rdata1 = 32'h5A5A5A5A;
        smp;
        n_cmp++;
        if ({mem_cs1, if_ready1} !== 2'b00) begin
            n_bad++;
            $display("FAIL lat1_c3: cs=%b ifr=%b required 0 0", mem_cs1, if_ready1);
        end
        tick;
        if_req1 = 1'b0;
        smp;
        n_cmp++;
        if (mem_cs1 !== 1'b1) begin
            n_bad++;
            $display("FAIL lat1_regrant: cs=%b required 1", mem_cs1);
        end
        tick;
        smp;
        n_cmp++;
        if ({if_ready1, if_rdata1} !== {1'b1, 32'h5A5A5A5A}) begin
            n_bad++;
            $display("FAIL lat1_dropped_req: ifr=%b ird=%h required 1 5a5a5a5a", if_ready1, if_rdata1);
        end
        tick;
    endtask

    task automatic test_fairness;
        logic [31:0] exp_addr [4];
`ifdef MEM_ARB_FAIRNESS_EN
        exp_addr = '{32'h40, 32'h40, 32'h8, 32'h40};
`else
        exp_addr = '{32'h40, 32'h40, 32'h40, 32'h40};
`endif
        tick;
        if_req  = 1'b1;
        if_addr = 32'h8;
        d_rd_en = 1'b1;
        d_addr  = 32'h40;
        for (int g = 0; g < 4; g++) begin
            tick;
            smp;
            n_cmp++;
            if ({mem_cs, freeze, mem_addr} !== {2'b11, exp_addr[g]}) begin
                n_bad++;
                $display("FAIL fair_grant%0d: cs=%b frz=%b addr=%h required 1 1 %h",
                         g, mem_cs, freeze, mem_addr, exp_addr[g]);
            end
            for (int c = 0; c < 5; c++) tick;
        end
        if_req  = 1'b0;
        d_rd_en = 1'b0;
        for (int c = 0; c < 8; c++) tick;
        smp;
        n_cmp++;
        if ({mem_cs, d_ready, if_ready, freeze} !== 4'b0000) begin
            n_bad++;
            $display("FAIL fair_quiet: cs=%b dr=%b ifr=%b frz=%b required 0 0 0 0", mem_cs, d_ready, if_ready, freeze);
        end
    endtask

    initial begin
        test_reset;
        test_read;
        test_write(1'b0);
        test_write(1'b1);
        test_contention;
        test_lat1;
        test_fairness;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
